// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin writeback arbiter for the register file write port
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [4*NUM_REQ-1:0]      req_rd,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      issue_valid,
    input  logic [3:0]                issue_rd,
    input  logic                      hold,
    output logic                      rf_write,
    output logic [3:0]                rf_rd,
    output logic [DATA_W-1:0]         rf_writeData,
    output logic [15:0]               busy,
    output logic                      err_spurious
);
    logic [1:0]         rr_ptr;
    logic [1:0]         gidx;
    logic [1:0]         idx;
    logic [2:0]         sum;
    logic               found;
    logic [NUM_REQ-1:0] gnt;
    logic               xfer;
    logic [15:0]        set_mask;
    logic [15:0]        clr_mask;

    // search from rr_ptr upward, wrapping modulo NUM_REQ, for the first valid requester
    always_comb begin
        found = 1'b0;
        gidx  = rr_ptr;
        sum   = '0;
        idx   = '0;
        gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + 3'(k);
            if (int'(sum) >= NUM_REQ) sum = sum - 3'(NUM_REQ);
            idx = sum[1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) gnt[gidx] = 1'b1;
        req_ready = (rst || hold) ? '0 : gnt;
        xfer      = |(req_valid & req_ready);
        set_mask  = issue_valid ? (16'd1 << issue_rd) : 16'd0;
        clr_mask  = rf_write ? (16'd1 << rf_rd) : 16'd0;
    end

    // output register, round-robin pointer, scoreboard (set beats clear) and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write     <= 1'b0;
            rf_rd        <= '0;
            rf_writeData <= '0;
            busy         <= '0;
            err_spurious <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            rf_write <= xfer;
            if (xfer) begin
                rf_rd        <= req_rd[{gidx, 2'b00} +: 4];
                rf_writeData <= req_data[int'(gidx)*DATA_W +: DATA_W];
                rr_ptr       <= (int'(gidx) == NUM_REQ-1) ? 2'd0 : gidx + 2'd1;
            end
            busy <= (busy & ~clr_mask) | set_mask;
            if (rf_write && !busy[rf_rd]) err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [11:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic        hold;
    logic        rf_write;
    logic [3:0]  rf_rd;
    logic [31:0] rf_writeData;
    logic [15:0] busy;
    logic        err_spurious;
    int checks = 0;
    int failures = 0;
    logic [3:0] issue_list [11] = '{1, 2, 3, 4, 6, 8, 10, 11, 12, 13, 14};
    logic [3:0] rr_list [6] = '{1, 2, 3, 4, 6, 8};
    int cnt [3];

    rf_wb_arbiter #(.NUM_REQ(3), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready), .issue_valid(issue_valid), .issue_rd(issue_rd), .hold(hold),
        .rf_write(rf_write), .rf_rd(rf_rd), .rf_writeData(rf_writeData), .busy(busy),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] rd, input logic [31:0] d);
        req_rd[i*4 +: 4]    = rd;
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        rst = 1'b1; req_valid = 3'b111; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; hold = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'b000);
        chk("rst_write", 32'(rf_write), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_spurious), 0);
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(req_ready), 32'b001);
        req_valid = 3'b000;
        // single write to R5
        issue_valid = 1'b1; issue_rd = 4'd5;
        step();
        issue_valid = 1'b0;
        chk("busy5_set", 32'(busy), 32'h0020);
        req_valid = 3'b010; set_req(1, 4'd5, 32'hDEADBEEF);
        #1;
        chk("single_ready", 32'(req_ready), 32'b010);
        step();
        req_valid = 3'b000;
        chk("single_write", 32'(rf_write), 1);
        chk("single_rd", 32'(rf_rd), 5);
        chk("single_data", rf_writeData, 32'hDEADBEEF);
        step();
        chk("busy5_clr", 32'(busy), 0);
        chk("single_idle", 32'(rf_write), 0);
        // mark destinations for the upcoming streams as in flight
        for (int i = 0; i < 11; i++) begin
            issue_valid = 1'b1; issue_rd = issue_list[i];
            step();
        end
        issue_valid = 1'b0;
        chk("busy_many", 32'(busy), 32'h7D5E);
        // lone grant to requester 2 brings the pointer back to 0
        req_valid = 3'b100; set_req(2, 4'd14, 32'h0000_000E);
        #1;
        chk("pre_ready", 32'(req_ready), 32'b100);
        step();
        req_valid = 3'b000;
        step();
        // round-robin with all three requesters continuously valid
        cnt = '{0, 0, 0};
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (cnt[i]*3 + i < 6) begin
                    req_valid[i] = 1'b1;
                    set_req(i, rr_list[cnt[i]*3 + i], 32'hA000_0000 + 32'(rr_list[cnt[i]*3 + i]));
                end else req_valid[i] = 1'b0;
            end
            #1;
            chk($sformatf("rr_ready%0d", c), 32'(req_ready), 32'(3'b001 << (c % 3)));
            step();
            cnt[c % 3]++;
            chk($sformatf("rr_write%0d", c), 32'(rf_write), 1);
            chk($sformatf("rr_rd%0d", c), 32'(rf_rd), 32'(rr_list[c]));
            chk($sformatf("rr_data%0d", c), rf_writeData, 32'hA000_0000 + 32'(rr_list[c]));
        end
        req_valid = 3'b000;
        step();
        chk("rr_idle", 32'(rf_write), 0);
        // hold during cycles 3-4
        req_valid = 3'b111;
        set_req(0, 4'd10, 32'h10); set_req(1, 4'd11, 32'h11); set_req(2, 4'd12, 32'h12);
        #1;
        chk("h1_ready", 32'(req_ready), 32'b001);
        step();
        set_req(0, 4'd13, 32'h13);
        chk("h2_write", 32'(rf_write), 1);
        chk("h2_rd", 32'(rf_rd), 10);
        chk("h2_ready", 32'(req_ready), 32'b010);
        step();
        req_valid = 3'b101; hold = 1'b1;
        #1;
        chk("h3_write", 32'(rf_write), 1);
        chk("h3_rd", 32'(rf_rd), 11);
        chk("h3_ready", 32'(req_ready), 32'b000);
        step();
        chk("h4_write", 32'(rf_write), 0);
        chk("h4_ready", 32'(req_ready), 32'b000);
        step();
        hold = 1'b0;
        #1;
        chk("h5_write", 32'(rf_write), 0);
        chk("h5_ready", 32'(req_ready), 32'b100);
        step();
        req_valid = 3'b001;
        chk("h6_write", 32'(rf_write), 1);
        chk("h6_rd", 32'(rf_rd), 12);
        chk("h6_ready", 32'(req_ready), 32'b001);
        step();
        req_valid = 3'b000;
        chk("h7_write", 32'(rf_write), 1);
        chk("h7_rd", 32'(rf_rd), 13);
        step();
        chk("h8_write", 32'(rf_write), 0);
        chk("drain_busy", 32'(busy), 0);
        chk("drain_err", 32'(err_spurious), 0);
        // set and clear of R7 in the same cycle
        issue_valid = 1'b1; issue_rd = 4'd7;
        step();
        issue_valid = 1'b0;
        chk("busy7_set", 32'(busy), 32'h0080);
        req_valid = 3'b001; set_req(0, 4'd7, 32'h77);
        #1;
        chk("col_ready", 32'(req_ready), 32'b001);
        step();
        req_valid = 3'b000;
        chk("col_write", 32'(rf_write), 1);
        chk("col_rd", 32'(rf_rd), 7);
        issue_valid = 1'b1; issue_rd = 4'd7;
        step();
        issue_valid = 1'b0;
        chk("col_busy", 32'(busy), 32'h0080);
        chk("col_err", 32'(err_spurious), 0);
        // spurious write to non-busy R9
        req_valid = 3'b010; set_req(1, 4'd9, 32'h99);
        #1;
        chk("sp_ready", 32'(req_ready), 32'b010);
        step();
        req_valid = 3'b000;
        chk("sp_rd", 32'(rf_rd), 9);
        chk("sp_err_pre", 32'(err_spurious), 0);
        step();
        chk("sp_err", 32'(err_spurious), 1);
        step();
        chk("sp_err_sticky", 32'(err_spurious), 1);
        // reset right after a grant drops the pending write
        req_valid = 3'b100; set_req(2, 4'd3, 32'h33);
        #1;
        chk("mr_ready", 32'(req_ready), 32'b100);
        step();
        req_valid = 3'b000; rst = 1'b1;
        step();
        chk("mr_write", 32'(rf_write), 0);
        chk("mr_err", 32'(err_spurious), 0);
        chk("mr_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        chk("mr_idle", 32'(rf_write), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
